// File: rtl/logic_clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel high/low/phase and common resync.
// Optional: LOGIC_CLK_DIV_MULTI_BYPASS_EN passes master_clk through on an all-zero config.
module logic_clk_div_multi #(
    parameter int N_CH         = 4,
    parameter int COUNTER_BITS = 16
) (
    input  logic                         master_clk,
    input  logic                         axi_resetn,
    input  logic [N_CH-1:0]              ch_en,
    input  logic                         sync_start,
    input  logic [N_CH*COUNTER_BITS-1:0] high_cycles,
    input  logic [N_CH*COUNTER_BITS-1:0] low_cycles,
    input  logic [N_CH*COUNTER_BITS-1:0] phase_cycles,
    output logic [N_CH-1:0]              output_clk,
    output logic [N_CH-1:0]              running,
    output logic [N_CH-1:0]              period_strobe
);

    localparam int CB = COUNTER_BITS;

    typedef logic [CB-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PHASE,
        ST_HIGH,
        ST_LOW
    } state_e;

    function automatic cnt_t nz(input cnt_t v);
        return (v == '0) ? cnt_t'(1) : v;
    endfunction

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_e state_q, state_d;
        cnt_t   cnt_q, cnt_d;
        cnt_t   h_q, h_d, l_q, l_d, p_q, p_d;
        logic   clk_q, clk_d;
        logic   strobe_q, strobe_d;
        cnt_t   h_in, l_in, p_in;
        logic   start;
        logic   bypass;

        assign h_in  = high_cycles[i*CB +: CB];
        assign l_in  = low_cycles[i*CB +: CB];
        assign p_in  = phase_cycles[i*CB +: CB];
        assign start = sync_start & ch_en[i];

`ifdef LOGIC_CLK_DIV_MULTI_BYPASS_EN
        assign bypass = ch_en[i] && (h_in == '0) && (l_in == '0);
`else
        assign bypass = 1'b0;
`endif

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            h_d     = h_q;
            l_d     = l_q;
            p_d     = p_q;
            if (bypass) begin
                // Parked in IDLE so leaving bypass waits for sync_start
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (start) begin
                h_d     = nz(h_in);
                l_d     = nz(l_in);
                p_d     = p_in;
                cnt_d   = cnt_t'(1);
                state_d = (p_in == '0) ? ST_HIGH : ST_PHASE;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_PHASE: begin
                        if (!ch_en[i]) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == p_q) begin
                            state_d = ST_HIGH;
                            cnt_d   = cnt_t'(1);
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_q == h_q) begin
                            state_d = ST_LOW;
                            cnt_d   = cnt_t'(1);
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    ST_LOW: begin
                        if (cnt_q != l_q) begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end else if (ch_en[i]) begin
                            h_d     = nz(h_in);
                            l_d     = nz(l_in);
                            state_d = ST_HIGH;
                            cnt_d   = cnt_t'(1);
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                endcase
            end
            clk_d    = (state_d == ST_HIGH);
            strobe_d = clk_d & ~clk_q;
        end

        always_ff @(posedge master_clk or negedge axi_resetn) begin
            if (!axi_resetn) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                h_q      <= '0;
                l_q      <= '0;
                p_q      <= '0;
                clk_q    <= 1'b0;
                strobe_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                h_q      <= h_d;
                l_q      <= l_d;
                p_q      <= p_d;
                clk_q    <= clk_d;
                strobe_q <= strobe_d;
            end
        end

        assign output_clk[i]    = bypass ? master_clk : clk_q;
        assign running[i]       = bypass | (state_q != ST_IDLE);
        assign period_strobe[i] = strobe_q;
    end

endmodule

// File: tb/tb_logic_clk_div_multi.sv
// Directed bench for logic_clk_div_multi: divide patterns, phase, reload,
// stop, async reset and the all-zero config.
module tb_logic_clk_div_multi;

    localparam int N  = 4;
    localparam int CB = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    ch_en;
    logic            sync_start;
    logic [N*CB-1:0] high_cycles;
    logic [N*CB-1:0] low_cycles;
    logic [N*CB-1:0] phase_cycles;
    logic [N-1:0]    output_clk;
    logic [N-1:0]    running;
    logic [N-1:0]    period_strobe;

    int n_tests = 0;
    int n_fail  = 0;

    logic_clk_div_multi #(.N_CH(N), .COUNTER_BITS(CB)) dut (
        .master_clk   (clk),
        .axi_resetn   (rst_n),
        .ch_en        (ch_en),
        .sync_start   (sync_start),
        .high_cycles  (high_cycles),
        .low_cycles   (low_cycles),
        .phase_cycles (phase_cycles),
        .output_clk   (output_clk),
        .running      (running),
        .period_strobe(period_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] h,
                          input logic [15:0] l, input logic [15:0] p);
        high_cycles[ch*CB +: CB]  = h;
        low_cycles[ch*CB +: CB]   = l;
        phase_cycles[ch*CB +: CB] = p;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        ch_en        = '0;
        sync_start   = 1'b0;
        high_cycles  = '0;
        low_cycles   = '0;
        phase_cycles = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start();
        sync_start = 1'b1;
        tick();
        sync_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();
        check("rst_out", output_clk, 0);
        check("rst_run", running, 0);
        check("rst_stb", period_strobe, 0);

        // 1: H=2 L=3 P=0 -> 11000 repeating
        set_ch(0, 2, 3, 0);
        ch_en = 4'b0001;
        tick();
        check("t1_no_launch", running, 0);
        start();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t1_out_k%0d", k), output_clk[0], (k % 5) < 2);
            check($sformatf("t1_stb_k%0d", k), period_strobe[0], (k % 5) == 0);
            tick();
        end

        // 2: ch1 phase 3 behind ch0, both 4/4
        do_reset();
        set_ch(0, 4, 4, 0);
        set_ch(1, 4, 4, 3);
        ch_en = 4'b0011;
        start();
        check("t2_run", running, 4'b0011);
        for (int k = 0; k < 20; k++) begin
            logic e0, e1;
            e0 = (k % 8) < 4;
            e1 = (k >= 3) && (((k - 3) % 8) < 4);
            check($sformatf("t2_out_k%0d", k), output_clk[1:0], {e1, e0});
            tick();
        end

        // 3: H changed mid-HIGH takes effect next period
        do_reset();
        set_ch(0, 4, 4, 0);
        ch_en = 4'b0001;
        start();
        for (int k = 0; k < 18; k++) begin
            logic e;
            e = (k < 4) || ((k >= 8) && (((k - 8) % 5) == 0));
            check($sformatf("t3_out_k%0d", k), output_clk[0], e);
            if (k == 1) high_cycles[0 +: CB] = 16'd1;
            tick();
        end

        // 4: drop ch_en mid-HIGH finishes the period
        do_reset();
        set_ch(0, 5, 5, 0);
        ch_en = 4'b0001;
        start();
        for (int k = 0; k < 15; k++) begin
            check($sformatf("t4_out_k%0d", k), output_clk[0], k < 5);
            check($sformatf("t4_run_k%0d", k), running[0], k < 10);
            if (k == 2) ch_en = 4'b0000;
            tick();
        end

        // 5: async reset mid-HIGH
        do_reset();
        set_ch(0, 4, 4, 0);
        ch_en = 4'b0001;
        start();
        check("t5_pre_out", output_clk[0], 1);
        check("t5_pre_stb", period_strobe[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out", output_clk, 0);
        check("t5_rst_run", running, 0);
        check("t5_rst_stb", period_strobe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t5_idle_run_k%0d", k), running[0], 0);
            check($sformatf("t5_idle_out_k%0d", k), output_clk[0], 0);
        end
        start();
        check("t5_restart_out", output_clk[0], 1);
        check("t5_restart_stb", period_strobe[0], 1);

        // 6: all-zero config
        do_reset();
        set_ch(0, 0, 0, 0);
        ch_en = 4'b0001;
`ifdef LOGIC_CLK_DIV_MULTI_BYPASS_EN
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t6_byp_hi_k%0d", k), output_clk[0], 1);
            check($sformatf("t6_byp_run_k%0d", k), running[0], 1);
            check($sformatf("t6_byp_stb_k%0d", k), period_strobe[0], 0);
            @(negedge clk);
            #1;
            check($sformatf("t6_byp_lo_k%0d", k), output_clk[0], 0);
        end
        ch_en = 4'b0000;
        tick();
        tick();
        check("t6_byp_exit_run", running[0], 0);
`else
        start();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t6_out_k%0d", k), output_clk[0], (k % 2) == 0);
            check($sformatf("t6_stb_k%0d", k), period_strobe[0], (k % 2) == 0);
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
